accum_alu_core: RTL and testbench

Parametrised successor to the combinational ui_in + uio_in adder: a registered, multi-channel add/subtract/accumulate engine with optional unsigned saturation, overflow reporting and valid/ready handshakes on both sides. It sits behind the Tiny Tapeout top-level wrapper, which maps pins onto its ports. It is also reusable as a standalone datapath core.

---
 rtl/accum_alu_core_if.sv | 81 ++++++++
 rtl/accum_alu_core.sv | 151 +++++++++++++++
 tb/tb_accum_alu_core.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_alu_core_if.sv
// ---------------------------------------------------------------------------
// accum_alu_core_if
//
// Purpose:
//   Bundles the request side, the result side and the status flags of the
//   accumulate/ALU core so that producer, core and consumer can be wired
//   with a single connection. Clock and reset are kept outside the bundle.
//
// Signal summary (direction as seen from the core, i.e. the slave modport):
//   ena         in   gates acceptance of new requests
//   in_valid    in   request present
//   in_ready    out  core can take a request this cycle
//   in_a        in   operand A                     [WIDTH]
//   in_b        in   operand B (ADD/SUB only)      [WIDTH]
//   in_ch       in   target channel                [CHW]
//   in_op       in   00 ADD, 01 SUB, 10 ACC, 11 CLR
//   in_sat      in   1 = saturate, 0 = wrap
//   out_valid   out  result register holds a result
//   out_ready   in   downstream takes the result
//   out_data    out  result                        [WIDTH]
//   out_ch      out  channel of the result         [CHW]
//   out_ovf     out  overflow/underflow for this result
//   ovf_sticky  out  per-channel sticky overflow   [CHANNELS]
// ---------------------------------------------------------------------------
interface accum_alu_core_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int CHW = $clog2(CHANNELS);

    logic                ena;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic [CHW-1:0]      in_ch;
    logic [1:0]          in_op;
    logic                in_sat;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [CHW-1:0]      out_ch;
    logic                out_ovf;
    logic [CHANNELS-1:0] ovf_sticky;

    // Producer/consumer side: drives requests and the result-side ready.
    modport master (
        output ena,
        output in_valid,
        output in_a,
        output in_b,
        output in_ch,
        output in_op,
        output in_sat,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch,
        input  out_ovf,
        input  ovf_sticky
    );

    // Core side.
    modport slave (
        input  ena,
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_ch,
        input  in_op,
        input  in_sat,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch,
        output out_ovf,
        output ovf_sticky
    );
endinterface

// File: rtl/accum_alu_core.sv
// ---------------------------------------------------------------------------
// accum_alu_core
//
// Purpose:
//   Registered multi-channel add / subtract / accumulate engine. Each
//   accepted request produces one result one cycle later in an output
//   register guarded by a valid/ready handshake. Every accepted request also
//   writes its final result into the accumulator of its channel, so ACC
//   always builds on the most recent result of that channel. Unsigned
//   overflow (carry) or underflow (borrow) is reported per result and
//   latched per channel in a sticky flag; optional saturation clamps the
//   result to all-ones (ADD/ACC) or zero (SUB).
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    --   accum_alu_core_if.slave (request, result and status signals)
//
// Parameters:
//   WIDTH     operand/result width (>= 2)
//   CHANNELS  number of accumulators (power of two, >= 2)
// ---------------------------------------------------------------------------
module accum_alu_core #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    accum_alu_core_if.slave       bus
);
    localparam int CHW = $clog2(CHANNELS);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    // State
    logic [WIDTH-1:0]    r_acc [CHANNELS];
    logic [WIDTH-1:0]    r_outData;
    logic [CHW-1:0]      r_outCh;
    logic                r_outOvf;
    logic                r_outValid;
    logic [CHANNELS-1:0] r_ovfSticky;

    // Datapath
    op_e                 w_op;
    logic                w_inReady;
    logic                w_accept;
    logic [WIDTH-1:0]    w_accSel;
    logic [WIDTH-1:0]    w_addend;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [WIDTH-1:0]    w_result;
    logic                w_ovf;

    // A new request can be taken whenever the result register is free or is
    // being emptied on this very edge; ena only gates the request side so a
    // pending result still drains while ena is low.
    assign w_inReady = bus.ena && (!r_outValid || bus.out_ready);
    assign w_accept  = bus.in_valid && w_inReady;

    assign w_op = op_e'(bus.in_op);

    // The accumulator is read before this edge's update, so back-to-back ACC
    // on one channel naturally sees the value written on the previous edge.
    assign w_accSel = r_acc[bus.in_ch];

    // ADD and ACC share one adder; only the second operand differs.
    assign w_addend = (w_op == OP_ACC) ? w_accSel : bus.in_b;

    // One extra bit holds the carry (sum) or the borrow (difference): for
    // a < b the WIDTH+1-bit wrap-around difference always has its top bit set.
    assign w_sum  = {1'b0, bus.in_a} + {1'b0, w_addend};
    assign w_diff = {1'b0, bus.in_a} - {1'b0, bus.in_b};

    // Final result selection including saturation.
    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (w_op)
            OP_ADD, OP_ACC: begin
                w_ovf    = w_sum[WIDTH];
                w_result = (w_ovf && bus.in_sat) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
            end
            OP_SUB: begin
                w_ovf    = w_diff[WIDTH];
                w_result = (w_ovf && bus.in_sat) ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
            end
            default: begin
                w_ovf    = 1'b0;
                w_result = '0;
            end
        endcase
    end

    // Per-channel accumulators: only the addressed channel is written, and
    // only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_accept) begin
            r_acc[bus.in_ch] <= w_result;
        end
    end

    // Result register: a new accept always wins (it also covers the case
    // where the old result is consumed on the same edge); otherwise the
    // register empties when the consumer takes it and is held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outCh    <= '0;
            r_outOvf   <= 1'b0;
        end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_outData  <= w_result;
            r_outCh    <= bus.in_ch;
            r_outOvf   <= w_ovf;
        end else if (bus.out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Sticky overflow flags: set by any overflowing result on the channel,
    // cleared only by a CLR on that channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovfSticky <= '0;
        end else if (w_accept) begin
            if (w_op == OP_CLR) begin
                r_ovfSticky[bus.in_ch] <= 1'b0;
            end else if (w_ovf) begin
                r_ovfSticky[bus.in_ch] <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.out_valid  = r_outValid;
    assign bus.out_data   = r_outData;
    assign bus.out_ch     = r_outCh;
    assign bus.out_ovf    = r_outOvf;
    assign bus.ovf_sticky = r_ovfSticky;

endmodule

// File: tb/tb_accum_alu_core.sv
// ---------------------------------------------------------------------------
// tb_accum_alu_core
//
// Purpose:
//   Self-checking bench for accum_alu_core (WIDTH=8, CHANNELS=4). Requests
//   come from a table of hand-computed vectors plus a few hand-written
//   sequences (backpressure, ena gating, asynchronous reset). Expected
//   results are queued when a request is accepted and compared when the
//   core presents them on the output handshake.
// ---------------------------------------------------------------------------
module tb_accum_alu_core;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int NVEC     = 18;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] ch;
        logic       sat;
        logic [7:0] expData;
        logic       expOvf;
        logic [3:0] expSticky;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
        logic       ovf;
        logic [3:0] sticky;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t sbQ[$];
    vec_t vecs[NVEC];

    accum_alu_core_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    accum_alu_core #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Generic comparison; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic driveReq(input logic [1:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [1:0] ch,
                            input logic sat);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_ch    = ch;
        bus.in_sat   = sat;
    endtask

    // Called at a negedge with a request already driven; returns just after
    // the accepting posedge, having queued the expected result.
    task automatic awaitAccept(input exp_t e);
        bit taken = 1'b0;
        for (int i = 0; i < 20 && !taken; i++) begin
            #1;
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                sbQ.push_back(e);
                taken = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept in 20 cycles, expected accept of data %0d", e.data);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        e.data   = v.expData;
        e.ch     = v.ch;
        e.ovf    = v.expOvf;
        e.sticky = v.expSticky;
        @(negedge clk);
        driveReq(v.op, v.a, v.b, v.ch, v.sat);
        awaitAccept(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Output monitor: mid low phase, after the driver has settled inputs.
    always @(negedge clk) begin
        exp_t e;
        logic expReady;
        #2;
        if (rst_n) begin
            expReady = bus.ena && (sbQ.size() == 0 || bus.out_ready);
            checkOutput("in_ready", bus.in_ready, expReady);
            checkOutput("out_valid", bus.out_valid, sbQ.size() != 0);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got data %0d, expected no result", bus.out_data);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("out_data", bus.out_data, e.data);
                    checkOutput("out_ch", bus.out_ch, e.ch);
                    checkOutput("out_ovf", bus.out_ovf, e.ovf);
                    checkOutput("ovf_sticky", bus.ovf_sticky, e.sticky);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        vec_t v;

        //            op     a       b       ch    sat   data    ovf   sticky
        vecs[0]  = '{2'b10, 8'd10,  8'd0,   2'd2, 1'b0, 8'd10,  1'b0, 4'b0000};
        vecs[1]  = '{2'b10, 8'd10,  8'd0,   2'd2, 1'b0, 8'd20,  1'b0, 4'b0000};
        vecs[2]  = '{2'b10, 8'd10,  8'd0,   2'd2, 1'b0, 8'd30,  1'b0, 4'b0000};
        vecs[3]  = '{2'b10, 8'd0,   8'd0,   2'd0, 1'b0, 8'd0,   1'b0, 4'b0000};
        vecs[4]  = '{2'b10, 8'd0,   8'd0,   2'd1, 1'b0, 8'd0,   1'b0, 4'b0000};
        vecs[5]  = '{2'b10, 8'd0,   8'd0,   2'd3, 1'b0, 8'd0,   1'b0, 4'b0000};
        vecs[6]  = '{2'b00, 8'd200, 8'd100, 2'd0, 1'b0, 8'd44,  1'b1, 4'b0001};
        vecs[7]  = '{2'b00, 8'd200, 8'd100, 2'd1, 1'b1, 8'd255, 1'b1, 4'b0011};
        vecs[8]  = '{2'b01, 8'd5,   8'd10,  2'd0, 1'b0, 8'd251, 1'b1, 4'b0011};
        vecs[9]  = '{2'b01, 8'd5,   8'd10,  2'd1, 1'b1, 8'd0,   1'b1, 4'b0011};
        vecs[10] = '{2'b01, 8'd10,  8'd5,   2'd2, 1'b0, 8'd5,   1'b0, 4'b0011};
        vecs[11] = '{2'b10, 8'd7,   8'd0,   2'd2, 1'b0, 8'd12,  1'b0, 4'b0011};
        vecs[12] = '{2'b10, 8'd255, 8'd0,   2'd3, 1'b1, 8'd255, 1'b0, 4'b0011};
        vecs[13] = '{2'b10, 8'd255, 8'd0,   2'd3, 1'b1, 8'd255, 1'b1, 4'b1011};
        vecs[14] = '{2'b11, 8'd99,  8'd42,  2'd3, 1'b0, 8'd0,   1'b0, 4'b0011};
        vecs[15] = '{2'b10, 8'd3,   8'd0,   2'd1, 1'b0, 8'd3,   1'b0, 4'b0011};
        vecs[16] = '{2'b10, 8'd5,   8'd200, 2'd0, 1'b0, 8'd0,   1'b1, 4'b0011};
        vecs[17] = '{2'b11, 8'd0,   8'd0,   2'd0, 1'b1, 8'd0,   1'b0, 4'b0010};

        bus.ena       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_ch     = '0;
        bus.in_op     = '0;
        bus.in_sat    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_out_valid", bus.out_valid, 1'b0);
        checkOutput("reset_out_data", bus.out_data, 8'd0);
        checkOutput("reset_sticky", bus.ovf_sticky, 4'b0000);
        checkOutput("reset_in_ready", bus.in_ready, 1'b1);

        // Table vectors, back-to-back with out_ready held high
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end
        idle();
        repeat (2) @(negedge clk);

        // Backpressure: one accept, then a second request must wait
        bus.out_ready = 1'b0;
        v = '{2'b10, 8'd1, 8'd0, 2'd2, 1'b0, 8'd13, 1'b0, 4'b0010};
        applyStimulus(v);
        @(negedge clk);
        driveReq(2'b10, 8'd1, 8'd0, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("held_data", bus.out_data, 8'd13);
            checkOutput("blocked_ready", bus.in_ready, 1'b0);
            @(negedge clk);
        end
        // ena low: pending result drains, request still not taken
        bus.ena       = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("ena_block_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("drained_valid", bus.out_valid, 1'b0);
        checkOutput("ena_block_ready2", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.ena = 1'b1;
        e = '{8'd14, 2'd2, 1'b0, 4'b0010};
        awaitAccept(e);
        idle();
        repeat (2) @(negedge clk);

        // Asynchronous reset with a pending result
        bus.out_ready = 1'b0;
        v = '{2'b10, 8'd4, 8'd0, 2'd1, 1'b0, 8'd7, 1'b0, 4'b0010};
        applyStimulus(v);
        idle();
        #3;
        rst_n = 1'b0;
        sbQ.delete();
        #1;
        checkOutput("async_out_valid", bus.out_valid, 1'b0);
        checkOutput("async_out_data", bus.out_data, 8'd0);
        checkOutput("async_out_ch", bus.out_ch, 2'd0);
        checkOutput("async_out_ovf", bus.out_ovf, 1'b0);
        checkOutput("async_sticky", bus.ovf_sticky, 4'b0000);
        checkOutput("async_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        v = '{2'b10, 8'd7, 8'd0, 2'd0, 1'b0, 8'd7, 1'b0, 4'b0000};
        applyStimulus(v);
        v = '{2'b10, 8'd7, 8'd0, 2'd2, 1'b0, 8'd7, 1'b0, 4'b0000};
        applyStimulus(v);
        idle();
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", sbQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
